// File: rtl/mem_axil_master.sv
// Bridges a valid/ready native memory port onto an AXI4-Lite master with one
// transaction in flight; every AXI and mem_ output comes straight from a flop.
module mem_axil_master #(
  parameter logic [2:0] PROT_INSTR = 3'b100,
  parameter logic [2:0] PROT_DATA  = 3'b000
) (
  input  logic        g_clk,
  input  logic        g_resetn,
  input  logic        mem_valid,
  input  logic        mem_instr,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic        mem_error,
  output logic        axi_awvalid,
  input  logic        axi_awready,
  output logic [31:0] axi_awaddr,
  output logic [2:0]  axi_awprot,
  output logic        axi_wvalid,
  input  logic        axi_wready,
  output logic [31:0] axi_wdata,
  output logic [3:0]  axi_wstrb,
  input  logic        axi_bvalid,
  output logic        axi_bready,
  input  logic [1:0]  axi_bresp,
  output logic        axi_arvalid,
  input  logic        axi_arready,
  output logic [31:0] axi_araddr,
  output logic [2:0]  axi_arprot,
  input  logic        axi_rvalid,
  output logic        axi_rready,
  input  logic [31:0] axi_rdata,
  input  logic [1:0]  axi_rresp
);

  // state   | meaning
  // IDLE    | waiting for mem_valid
  // RD_ADDR | arvalid up, waiting for arready
  // RD_DATA | rready up, waiting for rvalid
  // WR_REQ  | awvalid/wvalid up, each drops on its own handshake
  // WR_RESP | bready up, waiting for bvalid
  // DONE    | mem_ready pulse
  typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, DONE} state_t;

  state_t state_q;
  logic   awvalid_d;
  logic   wvalid_d;

  // A channel stays pending until the edge that samples its ready high.
  assign awvalid_d = axi_awvalid & ~axi_awready;
  assign wvalid_d  = axi_wvalid  & ~axi_wready;

  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      state_q     <= IDLE;
      mem_ready   <= 1'b0;
      mem_rdata   <= 32'h0;
      mem_error   <= 1'b0;
      axi_awvalid <= 1'b0;
      axi_awaddr  <= 32'h0;
      axi_awprot  <= 3'b000;
      axi_wvalid  <= 1'b0;
      axi_wdata   <= 32'h0;
      axi_wstrb   <= 4'h0;
      axi_bready  <= 1'b0;
      axi_arvalid <= 1'b0;
      axi_araddr  <= 32'h0;
      axi_arprot  <= 3'b000;
      axi_rready  <= 1'b0;
    end else begin
      mem_ready <= 1'b0;
      case (state_q)
        IDLE: begin
          if (mem_valid && !mem_ready) begin
            mem_error <= 1'b0;
            if (mem_wstrb == 4'h0) begin
              axi_araddr  <= mem_addr;
              axi_arprot  <= mem_instr ? PROT_INSTR : PROT_DATA;
              axi_arvalid <= 1'b1;
              state_q     <= RD_ADDR;
            end else begin
              axi_awaddr  <= mem_addr;
              axi_awprot  <= PROT_DATA;
              axi_wdata   <= mem_wdata;
              axi_wstrb   <= mem_wstrb;
              axi_awvalid <= 1'b1;
              axi_wvalid  <= 1'b1;
              state_q     <= WR_REQ;
            end
          end
        end
        RD_ADDR: begin
          if (axi_arready) begin
            axi_arvalid <= 1'b0;
            axi_rready  <= 1'b1;
            state_q     <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (axi_rvalid) begin
            axi_rready <= 1'b0;
            mem_rdata  <= axi_rdata;
            mem_error  <= (axi_rresp != 2'b00);
            mem_ready  <= 1'b1;
            state_q    <= DONE;
          end
        end
        WR_REQ: begin
          axi_awvalid <= awvalid_d;
          axi_wvalid  <= wvalid_d;
          if (!awvalid_d && !wvalid_d) begin
            axi_bready <= 1'b1;
            state_q    <= WR_RESP;
          end
        end
        WR_RESP: begin
          if (axi_bvalid) begin
            axi_bready <= 1'b0;
            mem_error  <= (axi_bresp != 2'b00);
            mem_ready  <= 1'b1;
            state_q    <= DONE;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_axil_master.md
MEM_AXIL_MASTER -- requirements
Module: mem_axil_master

Interface
REQ-001 Parameter PROT_INSTR, 3'b100, value driven on axi_arprot for instruction fetches.
REQ-002 Parameter PROT_DATA, 3'b000, value driven on axi_arprot/axi_awprot for data accesses.
REQ-003 g_clk  in  1  sole clock; all state SHALL update on rising edge only.
REQ-004 g_resetn  in  1  reset, synchronous and active-low.
REQ-005 mem_valid  in  1  native request valid; held high by requester until mem_ready.
REQ-006 mem_instr  in  1  request is instruction fetch.
REQ-007 mem_addr  in  32  byte address.
REQ-008 mem_wdata  in  32  write data.
REQ-009 mem_wstrb  in  4  byte strobes; 4'b0000 = read, non-zero = write.
REQ-010 mem_ready  out  1  single-cycle completion pulse.
REQ-011 mem_rdata  out  32  read data, valid with mem_ready on reads.
REQ-012 mem_error  out  1  non-OKAY response, valid with mem_ready.
REQ-013 axi_awvalid/axi_awready  out/in  1/1; axi_awaddr  out  32; axi_awprot  out  3.
REQ-014 axi_wvalid/axi_wready  out/in  1/1; axi_wdata  out  32; axi_wstrb  out  4.
REQ-015 axi_bvalid/axi_bready  in/out  1/1; axi_bresp  in  2.
REQ-016 axi_arvalid/axi_arready  out/in  1/1; axi_araddr  out  32; axi_arprot  out  3.
REQ-017 axi_rvalid/axi_rready  in/out  1/1; axi_rdata  in  32; axi_rresp  in  2.

Function
REQ-018 FSM states SHALL be IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, DONE; one transaction outstanding max.
REQ-019 IDLE: on edge with mem_valid=1 and mem_ready=0, latch addr/wdata/wstrb/instr; go RD_ADDR if wstrb==0, else WR_REQ.
REQ-020 RD_ADDR: axi_arvalid=1 with araddr=latched addr, arprot per mem_instr; on arready=1 go RD_DATA.
REQ-021 RD_DATA: axi_rready=1; on rvalid=1 capture rdata into mem_rdata, error=(rresp!=0), go DONE.
REQ-022 WR_REQ: axi_awvalid and axi_wvalid both raised on entry; each SHALL drop independently on the edge its ready is sampled high; go WR_RESP on the edge the last of the two completes (same edge if both ready together).
REQ-023 WR_RESP: axi_bready=1; on bvalid=1 error=(bresp!=0), go DONE.
REQ-024 DONE: mem_ready=1 for exactly one cycle, then IDLE unconditionally.
REQ-025 Address, data, strobe and prot outputs SHALL be stable while the corresponding valid is high and not yet accepted.
REQ-026 Valid outputs SHALL never depend combinationally on ready inputs; all AXI and mem_ outputs registered.
REQ-027 axi_rready/axi_bready SHALL be low outside RD_DATA/WR_RESP; stray rvalid/bvalid in other states ignored with no state change.
REQ-028 Minimum latency, zero-wait responder: mem_valid sampled E0, valid out E0+1, response captured E0+2, mem_ready high cycle after E0+2 (3 cycles request-to-ready for reads and writes).
REQ-029 Wait states on any ready/valid input SHALL extend latency one cycle each; no timeout, no abort.
REQ-030 mem_rdata SHALL hold its last captured value until the next read completes; unchanged by writes.
REQ-031 mem_error SHALL be cleared when a new request is accepted.
REQ-032 axi_awaddr/axi_araddr SHALL be the full 32-bit address, unaligned bits passed unmodified.

Reset
REQ-033 g_resetn=0 at an edge SHALL force IDLE; all valid/ready outputs, mem_ready, mem_error, mem_rdata, address/data/strobe/prot outputs = 0.
REQ-034 Reset mid-transaction SHALL abandon it without completion pulse; responder is reset with the same signal.
REQ-035 First request SHALL be accepted no earlier than the first edge with g_resetn=1.

Verification
REQ-036 Read 0x0000_0100, zero-wait responder, rdata 0xDEAD_BEEF, rresp 0 -> arvalid one cycle, mem_ready 3 cycles after mem_valid, mem_rdata 0xDEAD_BEEF, mem_error 0.
REQ-037 Write 0x0000_0200, wdata 0x1234_5678, wstrb 4'b0011; awready 2 cycles before wready -> awvalid drops first, wvalid held, bready only after both; mem_ready once.
REQ-038 Instruction fetch 0x0000_0000, arready delayed 4 cycles -> araddr/arprot=3'b100 stable throughout, mem_ready 7 cycles after mem_valid.
REQ-039 Read with rresp=2'b10 then write with bresp=2'b00 -> mem_error 1 on first pulse, 0 on second; mem_rdata unchanged by write.
REQ-040 g_resetn low while in RD_DATA, stray rvalid afterwards in IDLE -> no mem_ready, all outputs 0, rready stays 0.
REQ-041 Back-to-back reads with mem_valid held through ready pulse -> second request accepted only after DONE, one transaction per mem_ready.
